// File: rtl/dut_port_arb_if.sv
// Valid/ready channel bundle shared by the two request ports and the tagged output port.
// The src field is meaningful only on the output channel.
interface dut_intf #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              src;

  modport master     (output valid, data, input ready);
  modport slave      (input valid, data, output ready);
  modport src_master (output valid, data, src, input ready);
  modport src_slave  (input valid, data, src, output ready);
endinterface

// File: rtl/dut_port_arb.sv
// Two-channel round-robin ingress merger feeding a DEPTH-entry FIFO.
// Each FIFO word carries its source tag (0 = A, 1 = B).
module dut_port_arb #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  dut_intf.slave           a_if,
  dut_intf.slave           b_if,
  dut_intf.src_master      o_if,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  grant_e            last_grant_q, last_grant_d, grant;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   mem_d [DEPTH];
  logic [DATA_W-1:0] push_data;
  logic              full, a_rdy, b_rdy, push, pop;

  always_comb begin
    // Contention alternates; a lone requester always wins.
    grant = (last_grant_q == GNT_A) ? GNT_B : GNT_A;
    if (a_if.valid && !b_if.valid) grant = GNT_A;
    else if (!a_if.valid && b_if.valid) grant = GNT_B;

    full      = (count_q == CNT_W'(DEPTH));
    a_rdy     = !rst && !full && (grant == GNT_A);
    b_rdy     = !rst && !full && (grant == GNT_B);
    push      = (a_if.valid && a_rdy) || (b_if.valid && b_rdy);
    pop       = (count_q != '0) && o_if.ready;
    push_data = (grant == GNT_B) ? b_if.data : a_if.data;

    last_grant_d = push ? grant : last_grant_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q] = {grant == GNT_B, push_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_B;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage is never reset; the empty-FIFO output is forced to zero instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign a_if.ready            = a_rdy;
  assign b_if.ready            = b_rdy;
  assign o_if.valid            = (count_q != '0);
  assign {o_if.src, o_if.data} = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count                 = count_q;

endmodule

// File: tb/tb_dut_port_arb.sv
// Scoreboard bench for dut_port_arb: accepted pushes are queued, pops are checked in order,
// and occupancy/grant expectations come from an independent queue-based model.
module tb_dut_port_arb;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] count;

  dut_intf #(.DATA_W(DATA_W)) a_if ();
  dut_intf #(.DATA_W(DATA_W)) b_if ();
  dut_intf #(.DATA_W(DATA_W)) o_if ();

  dut_port_arb #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_if (a_if),
    .b_if (b_if),
    .o_if (o_if),
    .count(count)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              fails  = 0;
  logic [DATA_W:0] sb[$];
  bit              a_fire, b_fire;
  logic            a_hold, b_hold, exp_last_b;
  logic [DATA_W-1:0] a_hold_d, b_hold_d, a_word, b_word;
  logic            m_full, m_ea, m_eb;
  logic [DATA_W:0] m_exp;

  // Monitor: sampled on the falling edge, between input updates and active edges.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      a_fire = 1'b0; b_fire = 1'b0;
      a_hold = 1'b0; b_hold = 1'b0;
      exp_last_b = 1'b1;
    end else begin
      checks++;
      if (count !== CNT_W'(sb.size())) begin
        fails++; $display("FAIL count_model: got %0d want %0d", count, sb.size());
      end
      checks++;
      if (o_if.valid !== (sb.size() != 0)) begin
        fails++; $display("FAIL out_valid_model: got %0b want %0b", o_if.valid, sb.size() != 0);
      end
      m_full = (sb.size() == DEPTH);
      if (a_if.valid || b_if.valid) begin
        m_ea = a_if.valid && (!b_if.valid || exp_last_b) && !m_full;
        m_eb = b_if.valid && (!a_if.valid || !exp_last_b) && !m_full;
        checks++;
        if (a_if.ready !== m_ea || b_if.ready !== m_eb) begin
          fails++; $display("FAIL ready_model: got a=%0b b=%0b want a=%0b b=%0b",
                            a_if.ready, b_if.ready, m_ea, m_eb);
        end
      end
      if (a_hold && a_if.valid) begin
        checks++;
        if (a_if.data !== a_hold_d) begin
          fails++; $display("FAIL a_stable: got %0h want %0h", a_if.data, a_hold_d);
        end
      end
      if (b_hold && b_if.valid) begin
        checks++;
        if (b_if.data !== b_hold_d) begin
          fails++; $display("FAIL b_stable: got %0h want %0h", b_if.data, b_hold_d);
        end
      end
      a_fire = a_if.valid && a_if.ready;
      b_fire = b_if.valid && b_if.ready;
      if (o_if.valid && o_if.ready) begin
        checks++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL pop_empty: got pop with src=%0b data=%0h want none", o_if.src, o_if.data);
        end else begin
          m_exp = sb.pop_front();
          if ({o_if.src, o_if.data} !== m_exp) begin
            fails++; $display("FAIL pop_word: got src=%0b data=%0h want src=%0b data=%0h",
                              o_if.src, o_if.data, m_exp[DATA_W], m_exp[DATA_W-1:0]);
          end
        end
      end
      if (a_fire) begin sb.push_back({1'b0, a_if.data}); exp_last_b = 1'b0; end
      if (b_fire) begin sb.push_back({1'b1, b_if.data}); exp_last_b = 1'b1; end
      a_hold = a_if.valid && !a_if.ready; a_hold_d = a_if.data;
      b_hold = b_if.valid && !b_if.ready; b_hold_d = b_if.data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (a_fire) begin a_word = a_word + 8'd1; a_if.data = a_word; end
    if (b_fire) begin b_word = b_word + 8'd1; b_if.data = b_word; end
  endtask

  task automatic drain();
    a_if.valid = 1'b0; b_if.valid = 1'b0; o_if.ready = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) tick();
    o_if.ready = 1'b0;
    checks++;
    if (count !== '0) begin fails++; $display("FAIL drain: got count %0d want 0", count); end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_if.valid = 1'b1; b_if.valid = 1'b1;
    tick(); tick();
    checks++; if (count !== '0) begin fails++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (o_if.valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", o_if.valid); end
    checks++; if (o_if.data !== '0) begin fails++; $display("FAIL rst_data: got %0h want 0", o_if.data); end
    checks++; if (o_if.src !== 1'b0) begin fails++; $display("FAIL rst_src: got %0b want 0", o_if.src); end
    checks++; if (a_if.ready !== 1'b0) begin fails++; $display("FAIL rst_a_ready: got %0b want 0", a_if.ready); end
    checks++; if (b_if.ready !== 1'b0) begin fails++; $display("FAIL rst_b_ready: got %0b want 0", b_if.ready); end
    rst = 1'b0; a_if.valid = 1'b0; b_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    o_if.ready = 1'b0;
    a_word = 8'h11; a_if.data = a_word; a_if.valid = 1'b1;
    #1;
    checks++; if (o_if.valid !== 1'b0) begin fails++; $display("FAIL no_bypass: got %0b want 0", o_if.valid); end
    tick();
    a_if.valid = 1'b0;
    checks++; if (a_fire !== 1'b1) begin fails++; $display("FAIL single_accept: got %0b want 1", a_fire); end
    checks++; if (count !== CNT_W'(1)) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
    checks++; if (o_if.valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b want 1", o_if.valid); end
    checks++; if (o_if.data !== 8'h11) begin fails++; $display("FAIL single_data: got %0h want 11", o_if.data); end
    checks++; if (o_if.src !== 1'b0) begin fails++; $display("FAIL single_src: got %0b want 0", o_if.src); end
    drain();
  endtask

  task automatic test_alternate();
    rst = 1'b1; tick(); rst = 1'b0;
    a_if.valid = 1'b1; b_if.valid = 1'b1; o_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (a_fire !== (i % 2 == 0) || b_fire !== (i % 2 == 1)) begin
        fails++; $display("FAIL alt_grant[%0d]: got a=%0b b=%0b want a=%0b b=%0b",
                          i, a_fire, b_fire, i % 2 == 0, i % 2 == 1);
      end
      checks++;
      if (o_if.valid !== 1'b1 || o_if.src !== (i % 2 == 1)) begin
        fails++; $display("FAIL alt_src[%0d]: got valid=%0b src=%0b want valid=1 src=%0b",
                          i, o_if.valid, o_if.src, i % 2 == 1);
      end
    end
    drain();
  endtask

  task automatic test_full();
    o_if.ready = 1'b0; a_if.valid = 1'b1; b_if.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count !== CNT_W'((i + 1 < DEPTH) ? i + 1 : DEPTH)) begin
        fails++; $display("FAIL full_count[%0d]: got %0d want %0d", i, count, (i + 1 < DEPTH) ? i + 1 : DEPTH);
      end
    end
    checks++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
      fails++; $display("FAIL full_ready: got a=%0b b=%0b want 0 0", a_if.ready, b_if.ready);
    end
    o_if.ready = 1'b1; #1;
    checks++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
      fails++; $display("FAIL full_pop_ready: got a=%0b b=%0b want 0 0", a_if.ready, b_if.ready);
    end
    tick();
    o_if.ready = 1'b0;
    checks++; if (count !== CNT_W'(3)) begin fails++; $display("FAIL full_after_pop: got %0d want 3", count); end
    checks++;
    if (a_fire || b_fire) begin fails++; $display("FAIL full_no_push: got a=%0b b=%0b want 0 0", a_fire, b_fire); end
    tick();
    checks++;
    if (!(a_fire || b_fire) || count !== CNT_W'(DEPTH)) begin
      fails++; $display("FAIL full_refill: got push=%0b count=%0d want push=1 count=%0d", a_fire || b_fire, count, DEPTH);
    end
    drain();
  endtask

  task automatic test_steady();
    o_if.ready = 1'b0; a_if.valid = 1'b1;
    tick(); tick();
    checks++; if (count !== CNT_W'(2)) begin fails++; $display("FAIL steady_prefill: got %0d want 2", count); end
    o_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (count !== CNT_W'(2) || a_fire !== 1'b1) begin
        fails++; $display("FAIL steady[%0d]: got count=%0d push=%0b want count=2 push=1", i, count, a_fire);
      end
    end
    drain();
  endtask

  task automatic test_rst_mid();
    o_if.ready = 1'b0; a_if.valid = 1'b1; b_if.valid = 1'b1;
    tick(); tick(); tick();
    checks++; if (count !== CNT_W'(3)) begin fails++; $display("FAIL mid_prefill: got %0d want 3", count); end
    rst = 1'b1;
    tick();
    checks++; if (count !== '0) begin fails++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (o_if.valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %0b want 0", o_if.valid); end
    checks++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
      fails++; $display("FAIL mid_ready: got a=%0b b=%0b want 0 0", a_if.ready, b_if.ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (a_fire !== 1'b1 || b_fire !== 1'b0) begin
      fails++; $display("FAIL mid_first_grant: got a=%0b b=%0b want a=1 b=0", a_fire, b_fire);
    end
    drain();
  endtask

  task automatic test_hold();
    o_if.ready = 1'b0; b_if.valid = 1'b0;
    a_word = 8'h5A; a_if.data = a_word; a_if.valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      a_if.valid = (i % 2 == 0);
      b_if.valid = (i % 3 == 0);
      tick();
      checks++;
      if (o_if.valid !== 1'b1 || o_if.data !== 8'h5A || o_if.src !== 1'b0) begin
        fails++; $display("FAIL hold[%0d]: got valid=%0b data=%0h src=%0b want valid=1 data=5a src=0",
                          i, o_if.valid, o_if.data, o_if.src);
      end
    end
    drain();
  endtask

  initial begin
    a_if.valid = 1'b0; b_if.valid = 1'b0;
    a_if.src = 1'b0;   b_if.src = 1'b0;
    o_if.ready = 1'b0;
    a_word = 8'h20; b_word = 8'h80;
    a_if.data = a_word; b_if.data = b_word;
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_steady();
    test_rst_mid();
    test_hold();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
